// File: rtl/csc_pkg.sv
// Shared types and constants for the CSC stream controller slice.
// Optional feature macro used by the top: CSC_LINE_STATS_EN (per-line pixel count).
package csc_pkg;

    localparam int CSC_LATENCY_DEF = 4;

    typedef struct packed {
        logic [12:0] y;
        logic [11:0] u;
        logic [11:0] v;
    } yuv_pix_t;

    typedef logic [23:0] rgb_pix_t;

    typedef struct packed {
        logic sof;
        logic eol;
    } pix_tag_t;

    // One output FIFO entry: converted pixel plus its frame/line tags
    typedef struct packed {
        rgb_pix_t rgb;
        pix_tag_t tag;
    } res_word_t;

    // One slot of the tag pipe that shadows the CSC pipeline
    typedef struct packed {
        logic     vld;
        pix_tag_t tag;
    } tag_slot_t;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        RUN      = 2'd1,
        DRAIN    = 2'd2
    } ctrl_state_t;

    // Saturating 16-bit increment for the line-length counter
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

endpackage

// File: rtl/csc_result_fifo.sv
// Synchronous first-word-fall-through FIFO holding converted pixels and tags.
// rd_data always shows the oldest entry; it is only meaningful while !empty.
module csc_result_fifo
    import csc_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  res_word_t                wr_data,
    input  logic                     pop,
    output res_word_t                rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    res_word_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a write
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/csc_stream_ctrl.sv
// Scheduler around the free-running yuv_to_rgb converter: admits YUV pixels,
// shadows the CSC pipeline with a tag pipe, and buffers results for the scaler.
// Optional macro CSC_LINE_STATS_EN adds line_len / line_len_vld outputs.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// WAIT_SOF | hunting for start of frame; non-SOF input is accepted and dropped
// RUN      | every accepted pixel is issued into the CSC
// DRAIN    | input closed; waiting for in-flight pixels to land in the FIFO
module csc_stream_ctrl
    import csc_pkg::*;
#(
    parameter int CSC_LATENCY = CSC_LATENCY_DEF,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [12:0] s_y,
    input  logic [11:0] s_u,
    input  logic [11:0] s_v,
    input  logic        s_sof,
    input  logic        s_eol,
    output logic [12:0] csc_y,
    output logic [11:0] csc_u,
    output logic [11:0] csc_v,
    input  logic [23:0] csc_rgb,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [23:0] m_rgb,
    output logic        m_sof,
    output logic        m_eol
`ifdef CSC_LINE_STATS_EN
    ,
    output logic [15:0] line_len,
    output logic        line_len_vld
`endif
);

    localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_LIM = (CW+1)'(FIFO_DEPTH);

    ctrl_state_t   state;
    ctrl_state_t   state_nxt;
    tag_slot_t     tag_pipe [CSC_LATENCY];
    yuv_pix_t      csc_q;
    res_word_t     fifo_wr;
    res_word_t     fifo_rd;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] inflight;
    logic          credit;
    logic          issue;
    logic          retire;

    // Every issued pixel already owns a FIFO slot, so downstream stalls never lose data
    assign credit = ({1'b0, inflight} + {1'b0, fifo_count}) < DEPTH_LIM;
    assign retire = tag_pipe[CSC_LATENCY-1].vld;

    // Next-state, admission and issue decode
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        issue     = 1'b0;
        case (state)
            WAIT_SOF: begin
                // With en low, keep upstream flowing and throw the input away
                s_ready = en ? credit : 1'b1;
                if (s_valid && s_ready && en && s_sof) begin
                    issue     = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                s_ready = credit;
                if (s_valid && s_ready) begin
                    issue = 1'b1;
                    if (!en && s_eol) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight == '0) state_nxt = WAIT_SOF;
            end
            default: state_nxt = WAIT_SOF;
        endcase
        if (rst) begin
            s_ready = 1'b0;
            issue   = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_SOF;
        else     state <= state_nxt;
    end

    // CSC input register: issued pixel, otherwise black
    always_ff @(posedge clk) begin
        if (rst || !issue) csc_q <= '0;
        else               csc_q <= {s_y, s_u, s_v};
    end

    // Tag pipe tracking which CSC output slots carry real pixels
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CSC_LATENCY; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= issue ? {1'b1, s_sof, s_eol} : '0;
            for (int i = 1; i < CSC_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    // Pixels inside the CSC pipeline and not yet in the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({issue, retire})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    assign fifo_wr = {csc_rgb, tag_pipe[CSC_LATENCY-1].tag};

    csc_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (retire),
        .wr_data (fifo_wr),
        .pop     (m_valid && m_ready),
        .rd_data (fifo_rd),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign csc_y   = csc_q.y;
    assign csc_u   = csc_q.u;
    assign csc_v   = csc_q.v;
    assign m_valid = !fifo_empty;
    assign m_rgb   = fifo_rd.rgb;
    assign m_sof   = fifo_rd.tag.sof;
    assign m_eol   = fifo_rd.tag.eol;

`ifdef CSC_LINE_STATS_EN
    logic [15:0] line_cnt;
    logic [15:0] line_cnt_inc;

    assign line_cnt_inc = sat_inc16(line_cnt);

    // Per-line issued-pixel count, published with a one-cycle strobe at EOL
    always_ff @(posedge clk) begin
        if (rst) begin
            line_cnt     <= '0;
            line_len     <= '0;
            line_len_vld <= 1'b0;
        end else begin
            line_len_vld <= 1'b0;
            if (state_nxt == WAIT_SOF && state != WAIT_SOF) begin
                line_cnt <= '0;
            end else if (issue) begin
                if (s_eol) begin
                    line_len     <= line_cnt_inc;
                    line_len_vld <= 1'b1;
                    line_cnt     <= '0;
                end else begin
                    line_cnt <= line_cnt_inc;
                end
            end
        end
    end
`endif

endmodule
